// File: rtl/burst_adapter_pkg.sv
// Shared types and sizing constants for the line-to-burst adapter.
package burst_adapter_pkg;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int NUM_BEATS = LINE_BITS / BEAT_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } burst_state_t;

endpackage

// File: rtl/burst_counter.sv
// Two-bit beat counter: synchronous clear, increment, wraps 3 -> 0,
// and flags the final beat of a line.
module burst_counter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o,
    output logic       last_o
);

    logic [1:0] cnt_q;

    // Beat index register; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/line_burst_adapter.sv
// Services whole-line pmem reads/writes as four ascending 64-bit bursts.
// Handshake: a pmem request is held high until pmem_resp pulses for one
// cycle; on the burst side each cycle with burst_resp high completes the
// current beat (read data valid, or write beat accepted).
module line_burst_adapter
    import burst_adapter_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_burst  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pmem_address,
    input  logic                      pmem_read,
    input  logic                      pmem_write,
    input  logic [8*(2**s_offset)-1:0] pmem_wdata,
    output logic [8*(2**s_offset)-1:0] pmem_rdata,
    output logic                      pmem_resp,
    output logic [31:0]               burst_address,
    output logic                      burst_read,
    output logic                      burst_write,
    output logic [s_burst-1:0]        burst_wdata,
    input  logic [s_burst-1:0]        burst_rdata,
    input  logic                      burst_resp,
    output burst_state_t              dbg_state
);

    localparam int LW = 8 * (2 ** s_offset);
    localparam int BW = s_burst;

    burst_state_t  state_q;
    logic [LW-1:0] line_q;
    logic [LW-1:0] rdata_q;
    logic [31:0]   addr_q;
    logic          resp_q;
    logic          rd_q;
    logic          wr_q;

    logic [1:0]    cnt;
    logic          cnt_last;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          accept;
    logic          beat_done;

    // Line offset bits never reach the bus; the address is line-aligned.
    logic unused_offset_bits;
    assign unused_offset_bits = ^pmem_address[s_offset-1:0];

    assign accept    = (state_q == S_IDLE) && (pmem_write || pmem_read);
    assign beat_done = ((state_q == S_READ) || (state_q == S_WRITE)) && burst_resp;
    assign cnt_clr   = accept;
    assign cnt_inc   = beat_done;

    burst_counter u_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Transaction FSM with registered bus controls; line_q holds the write
    // line or the partially assembled read line, rdata_q only the finished one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pmem_write) begin
                        addr_q  <= {pmem_address[31:s_offset], {s_offset{1'b0}}};
                        line_q  <= pmem_wdata;
                        wr_q    <= 1'b1;
                        state_q <= S_WRITE;
                    end else if (pmem_read) begin
                        addr_q  <= {pmem_address[31:s_offset], {s_offset{1'b0}}};
                        rd_q    <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (burst_resp) begin
                        line_q[int'(cnt)*BW +: BW] <= burst_rdata;
                        if (cnt_last) begin
                            rdata_q <= {burst_rdata, line_q[LW-BW-1:0]};
                            rd_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (burst_resp && cnt_last) begin
                        wr_q    <= 1'b0;
                        resp_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = resp_q;
    assign burst_address = addr_q;
    assign burst_read    = rd_q;
    assign burst_write   = wr_q;
    assign burst_wdata   = (state_q == S_WRITE) ? line_q[int'(cnt)*BW +: BW] : '0;
    assign dbg_state     = state_q;

endmodule

// File: doc/line_burst_adapter.md
# line_burst_adapter

Physical-memory-side responder for the eviction buffer and caches. It accepts whole-line read and write requests on the 256-bit pmem interface and performs them as 4-beat, 64-bit bursts on the external memory bus. On reads it assembles the beats into a line; on writes it slices the line into beats. It sits between the eviction datapath's pmem_* port and main memory.

## Interface
Parameters:
- s_offset, 5, log2 of line bytes; line width = 8*2**s_offset (256)
- s_burst, 64, burst beat width in bits; beats per line = line width / s_burst (4)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- pmem_address  input  32  line request address; bits [s_offset-1:0] ignored
- pmem_read  input  1  line read request, held until pmem_resp
- pmem_write  input  1  line write request, held until pmem_resp
- pmem_wdata  input  256  line to write, stable while pmem_write is high
- pmem_rdata  output  256  assembled read line
- pmem_resp  output  1  one-cycle completion pulse
- burst_address  output  32  line-aligned burst address {addr[31:5], 5'b0}
- burst_read  output  1  burst read request
- burst_write  output  1  burst write request
- burst_wdata  output  64  current write beat
- burst_rdata  input  64  current read beat
- burst_resp  input  1  beat accepted (write) or beat valid (read)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - pmem_write high: latch the aligned address and pmem_wdata, clear the beat counter, go to WRITE.
  - Else pmem_read high: latch the address, clear the counter, go to READ.
  - Write has priority when both are high.
- READ:
  - burst_read = 1.
  - Each cycle with burst_resp = 1 stores burst_rdata into line slice [64*cnt+63 : 64*cnt] and increments cnt.
  - The capture at cnt = 3 moves to DONE.
- WRITE:
  - burst_write = 1; burst_wdata = latched line slice cnt.
  - Each burst_resp = 1 increments cnt; the beat at cnt = 3 moves to DONE.
- DONE: pmem_resp = 1 for one cycle, then IDLE.
- Beat order: beat 0 is bits [63:0], ascending.
- Beat counter: 2 bits, wraps 3 -> 0.
- burst_resp is ignored in IDLE and DONE.
- pmem_rdata holds the last assembled line until the next read overwrites it. Write transactions do not change pmem_rdata.
- Address and write data are latched at acceptance. Changes on the pmem_* inputs mid-transaction have no effect.

## Timing
- Reset (async assert, rst = 0):
  - State goes to IDLE, cnt = 0.
  - pmem_rdata = 0, pmem_resp = 0, burst_read = 0, burst_write = 0, burst_address = 0, burst_wdata = 0.
- Reset mid-burst: abort immediately. No pmem_resp is issued and the partial line is discarded (pmem_rdata = 0).
- Request sampled high in IDLE at edge N:
  - burst_read or burst_write is high from cycle N+1.
  - With zero-wait memory (burst_resp high N+1..N+4), pmem_resp is high in cycle N+5.
  - Each burst_resp low cycle adds one cycle.
- burst_read and burst_write are registered and drop in the DONE cycle.
- burst_wdata is valid in every WRITE cycle.
- pmem_rdata is valid when pmem_resp rises.
- The requester deasserts its request on the edge that ends the DONE cycle. A request still high in the following IDLE cycle is treated as a new transaction.

## Structure
- Package `burst_adapter_pkg`:
  - State enum typedef `burst_state_t`.
  - Constants `LINE_BITS`, `BEAT_BITS`, `NUM_BEATS`.
- One natural sub-module, `burst_counter`: 2-bit counter with clear, increment, and last-beat flag.
- Line assembly and slicing logic stays in the top module.

## Test plan
- Reset: hold rst = 0 with random inputs. All outputs must be 0. After release, the state is IDLE and nothing is asserted.
- Zero-wait read:
  - Stimulus: pmem_address = 0x0000_1234; beats 0x1111…, 0x2222…, 0x3333…, 0x4444….
  - Response: burst_address = 0x0000_1220; pmem_rdata = {0x4444…, 0x3333…, 0x2222…, 0x1111…}; pmem_resp exactly 5 cycles after the request.
- Wait-state read: burst_resp pattern 1,0,1,0,0,1,1. Correct line assembled, pmem_resp 8 cycles after the request.
- Write:
  - Stimulus: pmem_wdata = 0xDDDD…_CCCC…_BBBB…_AAAA….
  - Response: burst_wdata sequence 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD…, advancing only on burst_resp; pmem_rdata unchanged.
- Simultaneous pmem_read and pmem_write: a write burst occurs first. The still-high read then gets its own transaction after DONE.
- Reset after 2 read beats: outputs clear immediately and no pmem_resp occurs. A following read completes normally with cnt starting at 0.
